// File: rtl/sudoku_ctrl_pkg.sv
// Shared button indices, board size, write FSM states and wrap helpers
// for the sudoku cursor controller.
package sudoku_ctrl_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  localparam int BOARD_DIM = 9;

  typedef enum logic {
    IDLE,
    PEND
  } wr_state_e;

  function automatic logic [3:0] wrap_inc(
    input logic [3:0] v,
    input logic [3:0] lo,
    input logic [3:0] hi
  );
    return (v >= hi) ? lo : v + 4'd1;
  endfunction

  function automatic logic [3:0] wrap_dec(
    input logic [3:0] v,
    input logic [3:0] lo,
    input logic [3:0] hi
  );
    return (v <= lo) ? hi : v - 4'd1;
  endfunction

endpackage

// File: rtl/sudoku_cursor_ctrl_btn_repeat.sv
// Per-direction move pulse generator; the hold/repeat timer is built
// only when SUDOKU_AUTOREPEAT_EN is defined.
module btn_repeat #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  input  logic evt_i,
  input  logic block_i,
  output logic move_o
);

`ifdef SUDOKU_AUTOREPEAT_EN
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rpt;

  // cnt_q equals cycles since the press; after each repeat it is
  // rewound so the next repeat lands REPEAT_CYCLES later.
  always_comb begin
    cnt_d = cnt_q;
    rpt   = 1'b0;
    if (block_i || !level_i) begin
      cnt_d = '0;
    end else if (evt_i) begin
      cnt_d = CW'(1);
    end else if (cnt_q == CW'(HOLD_CYCLES)) begin
      rpt   = 1'b1;
      cnt_d = CW'(HOLD_CYCLES - REPEAT_CYCLES + 1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign move_o = ~block_i & (evt_i | rpt);
`else
  logic unused_ok;
  assign unused_ok = ^{clk, reset, level_i};
  assign move_o    = ~block_i & evt_i;
`endif

endmodule

// File: rtl/sudoku_cursor_ctrl.sv
// Cursor, digit and write-command controller for the 9x9 board.
// Auto-repeat of directions is enabled by SUDOKU_AUTOREPEAT_EN.
module sudoku_cursor_ctrl #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int BOARD_DIM     = sudoku_ctrl_pkg::BOARD_DIM
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] btn,
  input  logic        block,
  output logic [3:0]  cur_row,
  output logic [3:0]  cur_col,
  output logic [3:0]  cur_digit,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_row,
  output logic [3:0]  cmd_col,
  output logic [3:0]  cmd_value,
  output logic        start_pulse
);
  import sudoku_ctrl_pkg::*;

  localparam logic [3:0] MAXI = 4'(BOARD_DIM - 1);

  logic [11:0] btn_q, ev;
  logic [3:0]  mv;
  logic [3:0]  row_q, row_d, col_q, col_d, dig_q, dig_d;
  logic [3:0]  crow_q, crow_d, ccol_q, ccol_d, cval_q, cval_d;
  logic        start_q, start_d;
  wr_state_e   st_q, st_d;

  assign ev = btn & ~btn_q & {12{~block}};

  for (genvar i = 0; i < 4; i++) begin : g_dir
    btn_repeat #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_rep (
      .clk    (clk),
      .reset  (reset),
      .level_i(btn[i]),
      .evt_i  (ev[i]),
      .block_i(block),
      .move_o (mv[i])
    );
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    dig_d   = dig_q;
    crow_d  = crow_q;
    ccol_d  = ccol_q;
    cval_d  = cval_q;
    st_d    = st_q;
    start_d = ev[BTN_START];

    // Opposing directions cancel on their axis only.
    if (mv[BTN_UP] ^ mv[BTN_DOWN])
      row_d = mv[BTN_UP] ? wrap_dec(row_q, 4'd0, MAXI)
                         : wrap_inc(row_q, 4'd0, MAXI);
    if (mv[BTN_LEFT] ^ mv[BTN_RIGHT])
      col_d = mv[BTN_LEFT] ? wrap_dec(col_q, 4'd0, MAXI)
                           : wrap_inc(col_q, 4'd0, MAXI);
    if (ev[BTN_Y] ^ ev[BTN_X])
      dig_d = ev[BTN_Y] ? wrap_inc(dig_q, 4'd1, 4'd9)
                        : wrap_dec(dig_q, 4'd1, 4'd9);

    unique case (st_q)
      IDLE: begin
        if (ev[BTN_A] | ev[BTN_B]) begin
          crow_d = row_q;
          ccol_d = col_q;
          cval_d = ev[BTN_A] ? dig_q : 4'd0;
          st_d   = PEND;
        end
      end
      PEND: begin
        if (cmd_ready) st_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      dig_q   <= 4'd1;
      crow_q  <= '0;
      ccol_q  <= '0;
      cval_q  <= '0;
      start_q <= 1'b0;
      st_q    <= IDLE;
    end else begin
      btn_q   <= btn;
      row_q   <= row_d;
      col_q   <= col_d;
      dig_q   <= dig_d;
      crow_q  <= crow_d;
      ccol_q  <= ccol_d;
      cval_q  <= cval_d;
      start_q <= start_d;
      st_q    <= st_d;
    end
  end

  logic unused_ev;
  assign unused_ev = ^{ev[BTN_C], ev[BTN_Z], ev[BTN_MODE]};

  assign cur_row     = row_q;
  assign cur_col     = col_q;
  assign cur_digit   = dig_q;
  assign cmd_valid   = (st_q == PEND);
  assign cmd_row     = crow_q;
  assign cmd_col     = ccol_q;
  assign cmd_value   = cval_q;
  assign start_pulse = start_q;

endmodule

// File: tb/tb_sudoku_cursor_ctrl.sv
// Directed scoreboard bench for sudoku_cursor_ctrl (HOLD=20, REPEAT=5).
module tb_sudoku_cursor_ctrl;
  import sudoku_ctrl_pkg::*;

  localparam logic [11:0] K_UP    = 12'h001;
  localparam logic [11:0] K_DOWN  = 12'h002;
  localparam logic [11:0] K_LEFT  = 12'h004;
  localparam logic [11:0] K_RIGHT = 12'h008;
  localparam logic [11:0] K_A     = 12'h010;
  localparam logic [11:0] K_B     = 12'h020;
  localparam logic [11:0] K_START = 12'h080;
  localparam logic [11:0] K_X     = 12'h100;
  localparam logic [11:0] K_Y     = 12'h200;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] btn;
  logic        block;
  logic        cmd_ready;
  logic [3:0]  cur_row, cur_col, cur_digit;
  logic        cmd_valid;
  logic [3:0]  cmd_row, cmd_col, cmd_value;
  logic        start_pulse;

  sudoku_cursor_ctrl #(
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .block      (block),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .cur_digit  (cur_digit),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .cmd_value  (cmd_value),
    .start_pulse(start_pulse)
  );

  always #10 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;

  sb_t sb[$];
  int  ncmp = 0;
  int  nfail = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    sb_t e;
    ncmp++;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL sb_empty got %0d required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        nfail++;
        $error("FAIL %s got %0d required %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic press(input logic [11:0] m);
    btn = m;
    tick(1);
    btn = '0;
    tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    int pulses;
    logic [3:0] r0;
    btn = '0;
    block = 1'b0;
    cmd_ready = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);

    push("rst_row", 0);   chk(8'(cur_row));
    push("rst_col", 0);   chk(8'(cur_col));
    push("rst_digit", 1); chk(8'(cur_digit));
    push("rst_valid", 0); chk(8'(cmd_valid));
    push("rst_value", 0); chk(8'(cmd_value));
    push("rst_start", 0); chk(8'(start_pulse));

    repeat (3) press(K_RIGHT);
    push("right3_col", 3); chk(8'(cur_col));
    push("right3_row", 0); chk(8'(cur_row));
    press(K_UP);
    push("up_wrap_row", 8); chk(8'(cur_row));
    press(K_DOWN);
    push("down_wrap_row", 0); chk(8'(cur_row));

    do_reset();
    for (int i = 0; i < 9; i++) begin
      press(K_Y);
      push("y_inc", (i == 8) ? 8'd1 : 8'(i + 2));
      chk(8'(cur_digit));
    end
    press(K_X);
    push("x_wrap", 9); chk(8'(cur_digit));
    press(K_X | K_Y);
    push("xy_none", 9); chk(8'(cur_digit));
    press(K_LEFT);
    push("left_wrap_col", 8); chk(8'(cur_col));

    do_reset();
    repeat (2) press(K_DOWN);
    repeat (5) press(K_RIGHT);
    repeat (6) press(K_Y);
    press(K_A);
    push("a_valid", 1); chk(8'(cmd_valid));
    push("a_row", 2);   chk(8'(cmd_row));
    push("a_col", 5);   chk(8'(cmd_col));
    push("a_value", 7); chk(8'(cmd_value));
    press(K_DOWN);
    press(K_B);
    push("pend_valid", 1);  chk(8'(cmd_valid));
    push("pend_row", 2);    chk(8'(cmd_row));
    push("pend_value", 7);  chk(8'(cmd_value));
    push("pend_cur_row", 3); chk(8'(cur_row));
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    push("ack_valid", 0); chk(8'(cmd_valid));

    press(K_B);
    push("b_valid", 1); chk(8'(cmd_valid));
    push("b_row", 3);   chk(8'(cmd_row));
    push("b_value", 0); chk(8'(cmd_value));
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    press(K_A | K_B);
    push("ab_value", 7); chk(8'(cmd_value));
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    push("ab_ack", 0); chk(8'(cmd_valid));

    block = 1'b1;
    btn = '1;
    pulses = 0;
    repeat (3) begin
      tick(1);
      pulses += int'(start_pulse);
    end
    btn = '0;
    tick(1);
    pulses += int'(start_pulse);
    block = 1'b0;
    tick(1);
    pulses += int'(start_pulse);
    push("blk_row", 3);    chk(8'(cur_row));
    push("blk_col", 5);    chk(8'(cur_col));
    push("blk_digit", 7);  chk(8'(cur_digit));
    push("blk_valid", 0);  chk(8'(cmd_valid));
    push("blk_start", 0);  chk(8'(pulses));

    pulses = 0;
    btn = K_START;
    repeat (3) begin
      tick(1);
      pulses += int'(start_pulse);
    end
    btn = '0;
    repeat (2) begin
      tick(1);
      pulses += int'(start_pulse);
    end
    push("start_once", 1); chk(8'(pulses));

    do_reset();
    btn = K_DOWN;
    tick(41);
    btn = '0;
    tick(1);
`ifdef SUDOKU_AUTOREPEAT_EN
    r0 = 4'd6;
`else
    r0 = 4'd1;
`endif
    push("hold_row", 8'(r0)); chk(8'(cur_row));

    press(K_UP | K_DOWN);
    push("updown_row", 8'(r0)); chk(8'(cur_row));
    press(K_LEFT | K_RIGHT);
    push("lr_col", 0); chk(8'(cur_col));
    press(K_UP | K_RIGHT);
    push("diag_row", 8'(r0 - 4'd1)); chk(8'(cur_row));
    push("diag_col", 1); chk(8'(cur_col));

    press(K_A);
    push("pre_rst_valid", 1); chk(8'(cmd_valid));
    reset = 1'b1;
    #1;
    push("async_rst_valid", 0); chk(8'(cmd_valid));
    tick(1);
    reset = 1'b0;
    tick(1);
    push("post_rst_value", 0); chk(8'(cmd_value));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
